// File: rtl/dsram_responder.sv
// Responder end of the SRAM-like data bus: accepts req/addr_ok handshakes, services them
// from an internal word RAM and returns in-order data_ok/rdata responses after LATENCY cycles.
module dsram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        hold,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        resp_err
);

  localparam int CW    = $clog2(MAX_OUT + 1);
  localparam int PW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_en = 4'b0001 << off;
      2'd1:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      2'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(MAX_OUT - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  logic [31:0]           ram [DEPTH];
  logic [CW-1:0]         count;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [31:0]           q_data [MAX_OUT];
  logic                  q_err  [MAX_OUT];
  logic [2:0]            q_cd   [MAX_OUT];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  misaligned;
  logic [3:0]            be;
  logic                  accept;
  logic                  pop;
  logic [31:0]           load_word;
  logic                  unused_addr;

  assign idx         = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^data_sram_addr[31:DEPTH_LOG2+2];
  assign misaligned  = is_misaligned(data_sram_size, data_sram_addr[1:0]);
  assign be          = byte_en(data_sram_size, data_sram_addr[1:0]);

  // addr_ok looks only at registered occupancy, so a slot freed this cycle is reusable next cycle
  assign data_sram_addr_ok = !rst && !hold && (count < CW'(MAX_OUT));
  assign accept            = data_sram_req && data_sram_addr_ok;
  assign pop               = (count != '0) && (q_cd[head] == 3'd0);
  assign load_word         = (data_sram_wr || misaligned) ? 32'd0 : ram[idx];

  // RAM byte-lane writes on the accepting edge; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !misaligned) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          ram[idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
        end
      end
    end
  end

  // Response FIFO with per-entry countdown, occupancy counter and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count             <= '0;
      head              <= '0;
      tail              <= '0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= 32'd0;
      resp_err          <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        q_data[i] <= 32'd0;
        q_err[i]  <= 1'b0;
        q_cd[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (q_cd[i] != 3'd0) begin
          q_cd[i] <= q_cd[i] - 3'd1;
        end
      end
      if (accept) begin
        q_data[tail] <= load_word;
        q_err[tail]  <= misaligned;
        q_cd[tail]   <= CD_INIT;
        tail         <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      data_sram_data_ok <= pop;
      data_sram_rdata   <= pop ? q_data[head] : 32'd0;
      resp_err          <= pop ? q_err[head] : 1'b0;
    end
  end

endmodule
